// File: rtl/lmsm_sequencer_pkg.sv
// Shared definitions for the LM/SM burst sequencer: state encodings, opcodes,
// default widths and the address incrementer.
package lmsm_sequencer_pkg;

    localparam int DEF_NREGS = 8;
    localparam int DEF_AW    = 16;

    // Opcodes the decoder uses to form start/is_load
    localparam logic [3:0] OP_LM = 4'b0110;
    localparam logic [3:0] OP_SM = 4'b0111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } seqState_t;

    function automatic logic [15:0] incr16(input logic [15:0] a);
        return a + 16'd1;
    endfunction

endpackage

// File: rtl/lowest_set_enc8.sv
// 8-to-3 priority encoder: index of the lowest set bit, with a valid flag.
module lowest_set_enc8 (
    input  logic [7:0] vec,
    output logic [2:0] idx,
    output logic       valid
);

    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (vec[i] && !valid) begin
                idx   = 3'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lmsm_sequencer.sv
// Memory-stage controller for load/store-multiple: one register per cycle,
// lowest index first, consecutive addresses from the latched base.
module lmsm_sequencer
    import lmsm_sequencer_pkg::*;
#(
    parameter int NREGS = DEF_NREGS,
    parameter int AW    = DEF_AW,
    parameter int IDXW  = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_load,
    input  logic [NREGS-1:0] reg_mask,
    input  logic [AW-1:0]    base_addr,
    output logic [AW-1:0]    mem_addr,
    output logic             addr_sel,
    output logic             write_mem,
    output logic             rf_write,
    output logic [IDXW-1:0]  xfer_reg,
    output logic             stall,
    output logic             busy,
    output logic             done
);

    seqState_t        state, nextState;
    logic [NREGS-1:0] maskQ, maskNext;
    logic [AW-1:0]    addrQ;
    logic             loadQ;
    logic [IDXW-1:0]  idx;
    logic             anySet;

    lowest_set_enc8 uEnc (
        .vec   (maskQ),
        .idx   (idx),
        .valid (anySet)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            maskQ <= '0;
            addrQ <= '0;
            loadQ <= 1'b0;
        end else begin
            state <= nextState;
            if (state == IDLE && start) begin
                maskQ <= reg_mask;
                addrQ <= base_addr;
                loadQ <= is_load;
            end else if (state == XFER) begin
                maskQ <= maskNext;
                addrQ <= incr16(addrQ);
            end
        end
    end

    always_comb begin
        nextState = state;
        maskNext  = maskQ;
        mem_addr  = '0;
        addr_sel  = 1'b1;
        write_mem = 1'b0;
        rf_write  = 1'b0;
        xfer_reg  = '0;
        stall     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                // Freeze the instruction in its own start cycle
                stall = start;
                if (start)
                    nextState = (reg_mask != '0) ? XFER : DONE;
            end
            XFER: begin
                addr_sel       = 1'b0;
                busy           = 1'b1;
                stall          = 1'b1;
                xfer_reg       = idx;
                mem_addr       = addrQ;
                rf_write       = loadQ & anySet;
                write_mem      = ~loadQ & anySet;
                maskNext[idx]  = 1'b0;
                nextState      = (maskNext == '0) ? DONE : XFER;
            end
            DONE: begin
                done      = 1'b1;
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

endmodule

// File: tb/tb_lmsm_sequencer.sv
// Scoreboard bench for lmsm_sequencer: expected transfers are queued by the
// stimulus and popped by a monitor whenever a memory/register enable appears.
module tb_lmsm_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        is_load;
    logic [7:0]  reg_mask;
    logic [15:0] base_addr;
    logic [15:0] mem_addr;
    logic        addr_sel;
    logic        write_mem;
    logic        rf_write;
    logic [2:0]  xfer_reg;
    logic        stall;
    logic        busy;
    logic        done;

    typedef struct packed {
        logic        ld;
        logic [2:0]  r;
        logic [15:0] a;
    } xfer_t;

    xfer_t expQ[$];
    int    total = 0;
    int    bad   = 0;

    lmsm_sequencer #(.NREGS(8), .AW(16), .IDXW(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .is_load   (is_load),
        .reg_mask  (reg_mask),
        .base_addr (base_addr),
        .mem_addr  (mem_addr),
        .addr_sel  (addr_sel),
        .write_mem (write_mem),
        .rf_write  (rf_write),
        .xfer_reg  (xfer_reg),
        .stall     (stall),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: every visible transfer must match the head of the queue
    always @(negedge clk) begin
        if (!reset && (write_mem || rf_write)) begin
            xfer_t got;
            got = '{ld: rf_write, r: xfer_reg, a: mem_addr};
            total++;
            if (write_mem && rf_write) begin
                bad++;
                $display("FAIL both_enables: write_mem=%b rf_write=%b", write_mem, rf_write);
            end else if (expQ.size() == 0) begin
                bad++;
                $display("FAIL unexpected_xfer: got ld=%b r=%0d a=%h, none expected",
                         got.ld, got.r, got.a);
            end else begin
                xfer_t e;
                e = expQ.pop_front();
                if (got !== e) begin
                    bad++;
                    $display("FAIL xfer: got ld=%b r=%0d a=%h expected ld=%b r=%0d a=%h",
                             got.ld, got.r, got.a, e.ld, e.r, e.a);
                end
            end
        end
    end

    task automatic push(input logic ld, input logic [2:0] r, input logic [15:0] a);
        expQ.push_back('{ld: ld, r: r, a: a});
    endtask

    // Issue one instruction and measure stall cycles and done position
    task automatic burst(input string nm, input logic ld, input logic [7:0] m,
                         input logic [15:0] b, input int expStall);
        int stallCnt = 0;
        int doneAt   = -1;
        start = 1'b1; is_load = ld; reg_mask = m; base_addr = b;
        for (int c = 1; c <= 20 && doneAt < 0; c++) begin
            @(negedge clk);
            if (stall) stallCnt++;
            if (done) doneAt = c;
            @(posedge clk); #1;
            start = 1'b0;
        end
        check({nm, "_stall"}, stallCnt, expStall);
        check({nm, "_doneAt"}, doneAt, expStall + 1);
        check({nm, "_drained"}, expQ.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int doneAt;
        reset = 1'b1; start = 1'b0; is_load = 1'b0; reg_mask = '0; base_addr = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_out", {mem_addr, addr_sel, write_mem, rf_write, xfer_reg, stall, busy, done},
              {16'h0000, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0});
        @(posedge clk); #1;

        // SM, gapped mask
        push(1'b0, 3'd0, 16'h0040);
        push(1'b0, 3'd2, 16'h0041);
        burst("sm05", 1'b0, 8'b0000_0101, 16'h0040, 3);

        // LM, full mask
        for (int unsigned i = 0; i < 8; i++)
            push(1'b1, 3'(i), 16'h0010 + 16'(i));
        burst("lmFF", 1'b1, 8'hFF, 16'h0010, 9);

        // Zero mask: no transfers at all
        burst("lm00", 1'b1, 8'h00, 16'h1234, 1);

        // Address wrap
        push(1'b0, 3'd0, 16'hFFFF);
        push(1'b0, 3'd7, 16'h0000);
        burst("sm81", 1'b0, 8'b1000_0001, 16'hFFFF, 3);

        // start held through XFER and DONE; only the IDLE re-presentation is taken
        push(1'b0, 3'd0, 16'h0100);
        push(1'b0, 3'd1, 16'h0101);
        push(1'b0, 3'd0, 16'h0200);
        push(1'b0, 3'd1, 16'h0201);
        start = 1'b1; is_load = 1'b0; reg_mask = 8'h03; base_addr = 16'h0100;
        @(negedge clk);
        check("hold_c1", {stall, busy}, 2'b10);
        @(posedge clk); #1 reg_mask = 8'hFF; base_addr = 16'h0300;
        @(negedge clk);
        check("hold_c2", {stall, busy, addr_sel}, 3'b110);
        @(posedge clk); #1;
        @(negedge clk);
        check("hold_c3", {stall, busy}, 2'b11);
        @(posedge clk); #1 reg_mask = 8'h03; base_addr = 16'h0200;
        @(negedge clk);
        check("hold_done", {done, stall, busy}, 3'b100);
        @(posedge clk); #1;
        @(negedge clk);
        check("hold_reissue", {stall, busy, done}, 3'b100);
        @(posedge clk); #1 start = 1'b0;
        doneAt = -1;
        for (int c = 1; c <= 10 && doneAt < 0; c++) begin
            @(negedge clk);
            if (done) doneAt = c;
            @(posedge clk); #1;
        end
        check("hold_doneAt", doneAt, 3);
        check("hold_drained", expQ.size(), 0);

        // Reset in the second XFER cycle of an LM burst
        push(1'b1, 3'd0, 16'h0500);
        start = 1'b1; is_load = 1'b1; reg_mask = 8'h0F; base_addr = 16'h0500;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("rst_mid_out", {mem_addr, addr_sel, write_mem, rf_write, xfer_reg, stall, busy, done},
              {16'h0000, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0});
        repeat (4) @(posedge clk);
        #1;
        check("rst_mid_drained", expQ.size(), 0);
        check("rst_mid_idle", {busy, done, write_mem, rf_write}, 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
